uart_rx: RTL and testbench

Asynchronous serial receiver (8N1, LSB first) that turns the host RX line into a byte stream for the command path. It sits directly upstream of `cobs_decode`, driving its `i_data`/`i_valid` and honouring its `o_ready`. A one-byte holding register absorbs backpressure, and framing and overrun faults are flagged as pulses.

---
 rtl/uart_rx_if.sv | 14 +
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-stream handshake from uart_rx to its downstream consumer, plus fault pulses.
// A transfer happens on any cycle with valid && ready; data and valid hold steady until it does.
interface uart_rx_if #(
    parameter int DW = 8
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          frame_err;
    logic          overrun;

    modport master (output data, valid, frame_err, overrun, input ready);
    modport slave  (input data, valid, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 LSB-first serial receiver with a one-byte holding register on its output.
// Framing and overrun faults are reported as single-cycle pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DW           = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    uart_rx_if.master    bus,
    output logic [1:0]   dbg_state
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] HALF_TERM = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_TERM  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic          sync1;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DW-1:0] shreg;
    logic          stop_term;
    logic          deliver;

    assign dbg_state = state;
    assign stop_term = (state == STOP) && (cnt == BIT_TERM);
    assign deliver   = stop_term && rx_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1         <= 1'b1;
            rx_sync       <= 1'b1;
            rx_prev       <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            bus.data      <= '0;
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            sync1         <= rx;
            rx_sync       <= sync1;
            rx_prev       <= rx_sync;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    // Only a falling edge arms the receiver, so a held-low line stays idle.
                    if (rx_prev && !rx_sync) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_TERM) begin
                        cnt <= '0;
                        if (!rx_sync) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_TERM) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_sync;
                        if (idx == LAST_IDX) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (stop_term) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (!rx_sync) begin
                            bus.frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            // A new byte may replace the held one only if the held one leaves this cycle.
            if (deliver) begin
                if (!bus.valid || bus.ready) begin
                    bus.data  <= shreg;
                    bus.valid <= 1'b1;
                end else begin
                    bus.overrun <= 1'b1;
                end
            end else if (bus.valid && bus.ready) begin
                bus.valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a frame-level reference model.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int DW  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rdy = 1'b0;
    logic [1:0] dbg_state;

    uart_rx_if #(.DW(DW)) bus ();
    assign bus.ready = rdy;

    uart_rx #(.CLKS_PER_BIT(CPB), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: what the line carried, reduced to expected bytes and fault counts.
    logic [DW-1:0] exp_q[$];
    int            exp_fe = 0;
    int            exp_ov = 0;
    bit            hold_pending = 0;
    logic [DW-1:0] held;

    // Observations collected away from the active edge.
    logic [DW-1:0] got_q[$];
    int            got_t[$];
    int            fe_cnt = 0;
    int            ov_cnt = 0;
    int            hold_seen = 0;
    int            hold_bad = 0;
    int            cyc = 0;
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [DW-1:0] pd = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            pv <= 1'b0;
        end else begin
            if (pv && !pr) begin
                hold_seen <= hold_seen + 1;
                if (!bus.valid || bus.data !== pd) hold_bad <= hold_bad + 1;
            end
            if (bus.valid && rdy) begin
                got_q.push_back(bus.data);
                got_t.push_back(cyc);
            end
            if (bus.frame_err) fe_cnt <= fe_cnt + 1;
            if (bus.overrun) ov_cnt <= ov_cnt + 1;
            pv <= bus.valid;
            pr <= rdy;
            pd <= bus.data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_frame(input logic [DW-1:0] b, input bit stop_ok);
        if (!stop_ok) exp_fe++;
        else if (hold_pending) exp_ov++;
        else if (rdy) exp_q.push_back(b);
        else begin
            hold_pending = 1;
            held = b;
        end
    endtask

    task automatic set_ready(input bit r);
        rdy = r;
        if (r && hold_pending) begin
            exp_q.push_back(held);
            hold_pending = 0;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] b, input bit stop_ok, input int stop_len);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < DW; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB * stop_len);
        rx = 1'b1;
        model_frame(b, stop_ok);
    endtask

    initial begin
        int n0, f0, o0;
        logic [DW-1:0] b;
        bit ok;

        tick(3);
        check("rst_data", bus.data, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_ovr", bus.overrun, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        tick(5);

        // Single byte
        set_ready(1);
        n0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'hA5, 1, 1);
        tick(20);
        check("single_cnt", got_q.size() - n0, 1);
        check("single_data", got_q[n0], 8'hA5);
        check("single_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);

        // Backpressure
        set_ready(0);
        n0 = got_q.size(); o0 = ov_cnt;
        send_frame(8'h11, 1, 1);
        tick(4);
        send_frame(8'h22, 1, 1);
        tick(20);
        check("bp_valid", bus.valid, 1);
        check("bp_data", bus.data, 8'h11);
        check("bp_ovr", ov_cnt - o0, 1);
        set_ready(1);
        tick(4);
        check("bp_valid_fall", bus.valid, 0);
        tick(40);
        check("bp_cnt", got_q.size() - n0, 1);
        check("bp_taken", got_q[n0], 8'h11);

        // Framing error, then recovery
        n0 = got_q.size(); f0 = fe_cnt;
        send_frame(8'h3C, 0, 2);
        tick(10);
        send_frame(8'h00, 1, 1);
        tick(20);
        check("fe_cnt", fe_cnt - f0, 1);
        check("fe_deliv_cnt", got_q.size() - n0, 1);
        check("fe_next_data", got_q[n0], 8'h00);

        // Glitch shorter than half a bit
        n0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(30);
        check("glitch_state", dbg_state, 0);
        check("glitch_cnt", got_q.size() - n0, 0);
        check("glitch_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);
        send_frame(8'h7E, 1, 1);
        tick(20);
        check("glitch_next", got_q[n0], 8'h7E);

        // Reset mid-frame while a byte is being held
        set_ready(0);
        send_frame(8'h5A, 1, 1);
        tick(20);
        check("prerst_valid", bus.valid, 1);
        n0 = got_q.size();
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            tick(CPB);
        end
        tick(8);
        rst = 1'b1;
        hold_pending = 0;
        #1;
        check("midrst_data", bus.data, 0);
        check("midrst_valid", bus.valid, 0);
        check("midrst_flags", {bus.frame_err, bus.overrun}, 0);
        tick(3);
        check("midrst_state", dbg_state, 0);
        rst = 1'b0;
        tick(5);
        set_ready(1);
        send_frame(8'h01, 1, 1);
        tick(20);
        check("postrst_cnt", got_q.size() - n0, 1);
        check("postrst_data", got_q[n0], 8'h01);

        // Back-to-back frames
        n0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt;
        for (int i = 0; i < 3; i++) send_frame(DW'(i), 1, 1);
        tick(20);
        check("b2b_cnt", got_q.size() - n0, 3);
        for (int i = 0; i < 3; i++) check("b2b_data", got_q[n0 + i], i);
        check("b2b_gap01", got_t[n0 + 1] - got_t[n0], 10 * CPB);
        check("b2b_gap12", got_t[n0 + 2] - got_t[n0 + 1], 10 * CPB);
        check("b2b_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);

        // Randomized traffic: random bytes, gaps, bad stop bits and backpressure
        for (int k = 0; k < 30; k++) begin
            set_ready($urandom_range(0, 3) != 0);
            tick($urandom_range(1, 20));
            b  = DW'($urandom_range(0, 255));
            ok = ($urandom_range(0, 7) != 0);
            send_frame(b, ok, 1);
        end
        set_ready(1);
        tick(50);

        check("total_cnt", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("byte", got_q[i], exp_q[i]);
        end
        check("total_ferr", fe_cnt, exp_fe);
        check("total_ovr", ov_cnt, exp_ov);
        check("hold_stable", hold_bad, 0);
        check("hold_exercised", hold_seen > 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
